// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, drives instruction memory
// and buffers fetched words toward decode with redirect/fault.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  output logic        pc_misaligned
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] QD = QDEPTH[AW:0];

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [63:0]   fetch_pc;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic [63:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];

  logic full;
  logic pop;
  logic push;
  logic redir_ok;
  logic redir_bad;

  // Handshake and redirect qualification; redirect beats push.
  always_comb begin
    full      = (count == QD);
    pop       = out_valid & out_ready;
    redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
    redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
    push      = (state == RUN) & ~redirect_valid & (~full | pop);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: misaligned redirect faults, aligned one recovers.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN: begin
        if (redir_bad) state_nx = FAULT;
      end
      FAULT: begin
        if (redir_ok) state_nx = RUN;
      end
    endcase
  end

  // Outputs decoded from registers only; head zeroed when empty.
  always_comb begin
    pc_misaligned = (state == FAULT);
    imem_addr     = fetch_pc;
    out_valid     = (count != '0);
    out_instr     = 32'd0;
    out_pc        = 64'd0;
    if (out_valid) begin
      out_instr = q_instr[rptr];
      out_pc    = q_pc[rptr];
    end
  end

  // Fetch PC: load on aligned redirect, advance on push, wraps mod 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redir_ok) begin
      fetch_pc <= redirect_pc;
    end else if (push) begin
      fetch_pc <= fetch_pc + 64'd4;
    end
  end

  // Queue pointers and occupancy; any redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (push) begin
      q_pc[wptr]    <= fetch_pc;
      q_instr[wptr] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a scoreboard of
// expected head PCs, checked by a negedge monitor.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        pc_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_pc;

  instr_fetch_unit #(
    .RESET_PC(64'd40),
    .QDEPTH  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .pc_misaligned (pc_misaligned)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  assign imem_instr = mem(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    exp_q.push_back(pc);
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  // Monitor: every accepted head must be the next expected PC.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_head: got pc %h required none", out_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("head_pc", out_pc, mon_pc);
        chk("head_instr", {32'd0, out_instr}, {32'd0, mem(mon_pc)});
      end
    end else if (!out_valid) begin
      chk("idle_head_zero", {out_pc[31:0], out_instr}, 64'd0);
    end
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    step(2);
    chk("rst_imem_addr", imem_addr, 64'd40);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_misaligned", {63'd0, pc_misaligned}, 64'd0);

    // Reset stream.
    rst_n = 1'b1;
    chk("release_empty", {63'd0, out_valid}, 64'd0);
    step(1);
    chk("latency_valid", {63'd0, out_valid}, 64'd1);
    chk("latency_pc", out_pc, 64'd40);
    for (int i = 0; i < 4; i++) expect_pc(64'd40 + 64'(4 * i));
    step(4);

    // Reset mid-stream, then backpressure after release.
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_addr", imem_addr, 64'd40);
    out_ready = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_head", out_pc, 64'd40);
    chk("bp_addr_hold", imem_addr, 64'd48);
    expect_pc(64'd40);
    expect_pc(64'd44);
    expect_pc(64'd48);
    out_ready = 1'b1;
    step(3);
    expect_pc(64'd52);
    expect_pc(64'd56);
    step(2);

    // Redirect with a simultaneous pop of PC 60.
    chk("pre_redir_head", out_pc, 64'd60);
    expect_pc(64'd60);
    redirect(64'd200);
    chk("redir_addr", imem_addr, 64'd200);
    chk("redir_bubble", {63'd0, out_valid}, 64'd0);
    expect_pc(64'd200);
    expect_pc(64'd204);
    step(3);
    out_ready = 1'b0;

    // Redirect into a full queue.
    step(1);
    chk("full_addr", imem_addr, 64'd216);
    chk("full_head", out_pc, 64'd208);
    redirect(64'h100);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_addr", imem_addr, 64'h100);
    step(1);
    chk("flush_new_head", out_pc, 64'h100);
    expect_pc(64'h100);
    expect_pc(64'h104);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;

    // Misaligned redirect and recovery.
    redirect(64'h102);
    chk("mis_flag", {63'd0, pc_misaligned}, 64'd1);
    chk("mis_valid", {63'd0, out_valid}, 64'd0);
    chk("mis_addr", imem_addr, 64'h10C);
    out_ready = 1'b1;
    step(3);
    chk("mis_flag_hold", {63'd0, pc_misaligned}, 64'd1);
    chk("mis_addr_hold", imem_addr, 64'h10C);
    chk("mis_no_push", {63'd0, out_valid}, 64'd0);
    redirect(64'h101);
    chk("mis_again", {63'd0, pc_misaligned}, 64'd1);
    chk("mis_again_addr", imem_addr, 64'h10C);
    redirect(64'h80);
    chk("recover_flag", {63'd0, pc_misaligned}, 64'd0);
    chk("recover_addr", imem_addr, 64'h80);
    expect_pc(64'h80);
    expect_pc(64'h84);
    expect_pc(64'h88);
    step(4);

    // PC wrap across 2^64.
    chk("pre_wrap_head", out_pc, 64'h8C);
    expect_pc(64'h8C);
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    chk("wrap_target", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    expect_pc(64'hFFFF_FFFF_FFFF_FFF8);
    expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
    expect_pc(64'd0);
    expect_pc(64'd4);
    step(5);
    chk("wrap_addr", imem_addr, 64'd12);

    // Asynchronous reset mid-stream restarts at RESET_PC.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_addr", imem_addr, 64'd40);
    chk("mid_rst_flag", {63'd0, pc_misaligned}, 64'd0);
    step(1);
    rst_n = 1'b1;
    expect_pc(64'd40);
    expect_pc(64'd44);
    step(3);
    out_ready = 1'b0;
    step(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end of the 64-bit MIPS datapath. It owns the program counter, drives the word address into the combinational instruction memory (`instrMem`: 64-bit address in, 32-bit instruction out, same-cycle read), and buffers fetched instructions in a small FIFO toward decode. The FIFO uses a valid/ready handshake. Decode/execute can redirect the PC on branches and jumps, which flushes the buffer.

## Interface
- `RESET_PC`, 64'd0: PC loaded on reset.
- `QDEPTH`, 2: fetch queue depth; a power of two, at least 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  64: byte address to instruction memory; equals the internal `fetch_pc`.
- `imem_instr`  in  32: instruction at `imem_addr`, valid in the same cycle.
- `redirect_valid`  in  1: load a new PC and flush the queue.
- `redirect_pc`  in  64: target PC, sampled when `redirect_valid` is 1.
- `out_valid`  out  1: queue head holds a valid instruction.
- `out_instr`  out  32: head instruction; 0 when `out_valid` is 0.
- `out_pc`  out  64: PC of the head instruction; 0 when `out_valid` is 0.
- `out_ready`  in  1: decode accepts the head this cycle.
- `pc_misaligned`  out  1: sticky fault flag; set by a misaligned redirect.

## Operation
- **State machine:** RUN and FAULT. Reset enters RUN.
- **RUN:**
  - push = (count < QDEPTH) or pop, where pop = `out_valid` & `out_ready`.
  - On a push, the entry {`fetch_pc`, `imem_instr`} is written at the tail and `fetch_pc` += 4.
  - Push and pop may occur in the same cycle, including when the queue is full; count is then unchanged.
- **PC wrap:** `fetch_pc` is modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0, with no flag.
- **Redirect:** `redirect_valid` has priority over push.
  - The queue is cleared (count = 0) and there is no push that cycle.
  - A handshake completing in the same cycle still counts as consumed by decode.
  - If `redirect_pc[1:0]` == 0: `fetch_pc` <= `redirect_pc` and the state stays RUN.
  - Otherwise: `fetch_pc` is unchanged, `pc_misaligned` <= 1, and the state moves to FAULT.
- **FAULT:**
  - No pushes.
  - The queue stays empty because the redirect flushed it.
  - `imem_addr` holds.
  - An aligned redirect returns the state to RUN, clears `pc_misaligned`, and loads `redirect_pc`.
  - A further misaligned redirect keeps the state in FAULT.
- **Reset:**
  - Asynchronous, at any time including mid-stream.
  - Clears the queue, sets `fetch_pc` = RESET_PC, clears `pc_misaligned`, and enters RUN.
  - `RESET_PC` must be word-aligned.
- **Queue implementation:** circular buffer with read/write pointers of log2(QDEPTH) bits that wrap naturally. Count has log2(QDEPTH)+1 bits.

## Timing
- **Reset values:**
  - `imem_addr` = RESET_PC.
  - `out_valid` = 0.
  - `out_instr` = 0.
  - `out_pc` = 0.
  - `pc_misaligned` = 0.
- **Fetch latency:** the address is presented in cycle N; the instruction is visible at the queue head (`out_valid` = 1) in cycle N+1.
- **Throughput:** with `out_ready` held at 1, one instruction per cycle and `out_pc` increments by 4 every cycle.
- **Backpressure:** with `out_ready` = 0, the queue fills in QDEPTH cycles. `imem_addr` then holds and the head stays stable.
- **Redirect timing:**
  - `redirect_valid` in cycle N.
  - Cycle N+1: `imem_addr` = target and `out_valid` = 0.
  - Cycle N+2: first target instruction appears at the head.
  - Redirect penalty is 1 bubble.
- **Fault timing:** `pc_misaligned` rises in the cycle after the misaligned redirect.
- **Handshake rules:** no combinational path from `out_ready` to `out_valid`. `imem_addr` depends only on registers.

## Test plan
- **Reset stream:** reset, then release `rst_n` with RESET_PC = 40 and `out_ready` = 1. Required: `out_pc` = 40, 44, 48, … on consecutive cycles starting one cycle after release, with `out_instr` matching the memory contents at each address.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles. Required: the queue holds 2 entries (PC 40, 44) and `imem_addr` stays at 48. Then release: PCs 40, 44, 48 arrive in order with no loss or duplication.
- **Redirect with simultaneous pop:** while streaming at PC 60, assert `redirect_valid` with `redirect_pc` = 200. Required: PC 60 is consumed, there is one bubble, then `out_pc` = 200, 204.
- **Redirect into a full queue:** fill the queue, then redirect to 0x100 while `out_ready` = 0. Required: the queue is flushed, 0x100 is the next head, and no stale entry emerges.
- **Misaligned redirect:** redirect to 0x102. Required: `pc_misaligned` = 1, `out_valid` stays 0 and `imem_addr` is frozen. Then redirect to 0x80: the flag clears and 0x80 streams.
- **Wrap and mid-stream reset:**
  - Redirect to 64'hFFFF_FFFF_FFFF_FFF8. Required: PCs …FFF8, …FFFC, 0, 4.
  - Assert `rst_n` = 0 asynchronously mid-stream. Required: `out_valid` drops immediately and the stream restarts at RESET_PC.
